// File: rtl/gfx256_ztest_if.sv
// Handshake bundles for the depth-test stage: interpolated fragment stream
// (in and out) and the 32-bit depth-memory master port.
interface gfx256_frag_if #(
   parameter int point_width = 16
);
   logic                   write;
   logic                   ack;
   logic [point_width-1:0] x;
   logic [point_width-1:0] y;
   logic [point_width-1:0] z;
   logic [point_width-1:0] u;
   logic [point_width-1:0] v;
   logic [31:0]            color;
   logic [7:0]             a;

   modport master (output write, x, y, z, u, v, color, a, input ack);
   modport slave  (input write, x, y, z, u, v, color, a, output ack);
endinterface

interface gfx256_zmem_if #(
   parameter int addr_width = 32
);
   logic [addr_width-1:0] addr;
   logic                  rd;
   logic                  wr;
   logic [3:0]            sel;
   logic [31:0]           wdata;
   logic [31:0]           rdata;
   logic                  ack;

   modport master (output addr, rd, wr, sel, wdata, input rdata, ack);
   modport slave  (input addr, rd, wr, sel, wdata, output rdata, ack);
endinterface

// File: rtl/gfx256_ztest.sv
// Depth test between interpolator and fragment sink: reads the stored 16-bit
// depth, forwards passing fragments, then writes their depth back.
module gfx256_ztest #(
   parameter int point_width = 16,
   parameter int addr_width  = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   zbuffer_enable_i,
   input  logic [addr_width-1:0]  zbuffer_base_i,
   input  logic [point_width-1:0] target_width_i,
   gfx256_frag_if.slave           frag_in,
   gfx256_frag_if.master          frag_out,
   gfx256_zmem_if.master          zmem
);

   typedef enum logic [2:0] {
      IDLE,
      ZREAD,
      COMPARE,
      FWD,
      ZWRITE,
      ACK
   } state_t;

   state_t                 state_reg;
   logic [point_width-1:0] x_reg;
   logic [point_width-1:0] y_reg;
   logic [point_width-1:0] z_reg;
   logic [point_width-1:0] u_reg;
   logic [point_width-1:0] v_reg;
   logic [31:0]            color_reg;
   logic [7:0]             a_reg;
   logic [addr_width-1:0]  addr_reg;
   logic [point_width-1:0] stored_z_reg;
   logic                   write_reg;
   logic                   ack_reg;
   logic                   rd_reg;
   logic                   wr_reg;
   logic [3:0]             sel_reg;

   logic [2*point_width-1:0] pix_idx;
   logic [2*point_width:0]   byte_off;
   logic [addr_width-1:0]    z_addr_calc;
   logic [31:0]              wdata_rep;

   // Unsigned pixel index; the 2*point_width product cannot overflow with x added.
   assign pix_idx     = {{point_width{1'b0}}, frag_in.y} * {{point_width{1'b0}}, target_width_i}
                      + {{point_width{1'b0}}, frag_in.x};
   assign byte_off    = {pix_idx, 1'b0};
   assign z_addr_calc = zbuffer_base_i + addr_width'(byte_off);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_wdata
         assign wdata_rep[gi*point_width +: point_width] = z_reg;
      end
   endgenerate

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg    <= IDLE;
         x_reg        <= '0;
         y_reg        <= '0;
         z_reg        <= '0;
         u_reg        <= '0;
         v_reg        <= '0;
         color_reg    <= '0;
         a_reg        <= '0;
         addr_reg     <= '0;
         stored_z_reg <= '0;
         write_reg    <= 1'b0;
         ack_reg      <= 1'b0;
         rd_reg       <= 1'b0;
         wr_reg       <= 1'b0;
         sel_reg      <= 4'b0000;
      end else begin
         case (state_reg)
            IDLE: begin
               if (frag_in.write) begin
                  x_reg     <= frag_in.x;
                  y_reg     <= frag_in.y;
                  z_reg     <= frag_in.z;
                  u_reg     <= frag_in.u;
                  v_reg     <= frag_in.v;
                  color_reg <= frag_in.color;
                  a_reg     <= frag_in.a;
                  addr_reg  <= z_addr_calc;
                  if (zbuffer_enable_i) begin
                     rd_reg    <= 1'b1;
                     state_reg <= ZREAD;
                  end else begin
                     write_reg <= 1'b1;
                     state_reg <= FWD;
                  end
               end
            end
            ZREAD: begin
               if (zmem.ack) begin
                  rd_reg       <= 1'b0;
                  stored_z_reg <= addr_reg[1] ? zmem.rdata[2*point_width-1:point_width]
                                              : zmem.rdata[point_width-1:0];
                  state_reg    <= COMPARE;
               end
            end
            COMPARE: begin
               // Equal depth is a reject: only strictly nearer-by-sign fragments pass.
               if ($signed(z_reg) > $signed(stored_z_reg)) begin
                  write_reg <= 1'b1;
                  state_reg <= FWD;
               end else begin
                  ack_reg   <= 1'b1;
                  state_reg <= ACK;
               end
            end
            FWD: begin
               if (frag_out.ack) begin
                  write_reg <= 1'b0;
                  if (zbuffer_enable_i) begin
                     wr_reg    <= 1'b1;
                     sel_reg   <= addr_reg[1] ? 4'b1100 : 4'b0011;
                     state_reg <= ZWRITE;
                  end else begin
                     ack_reg   <= 1'b1;
                     state_reg <= ACK;
                  end
               end
            end
            ZWRITE: begin
               if (zmem.ack) begin
                  wr_reg    <= 1'b0;
                  sel_reg   <= 4'b0000;
                  ack_reg   <= 1'b1;
                  state_reg <= ACK;
               end
            end
            ACK: begin
               ack_reg   <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign frag_in.ack    = ack_reg;
   assign frag_out.write = write_reg;
   assign frag_out.x     = x_reg;
   assign frag_out.y     = y_reg;
   assign frag_out.z     = z_reg;
   assign frag_out.u     = u_reg;
   assign frag_out.v     = v_reg;
   assign frag_out.color = color_reg;
   assign frag_out.a     = a_reg;
   assign zmem.addr      = addr_reg;
   assign zmem.rd        = rd_reg;
   assign zmem.wr        = wr_reg;
   assign zmem.sel       = sel_reg;
   assign zmem.wdata     = wdata_rep;

endmodule
